// File: rtl/bp_cce_cfg_endpoint.sv
// Config-bus endpoint for the CCE: mode/freeze/hio registers plus ucode RAM access.
// Optional read path enabled by defining BP_CFG_ENDPOINT_RD_EN.

package bp_cce_cfg_endpoint_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

  typedef struct packed {
    int unsigned paddr_width;
    int unsigned did_width;
    int unsigned lce_id_width;
    int unsigned lce_assoc;
  } bp_proc_param_s;

  function automatic bp_proc_param_s bp_get_proc_params(bp_params_e cfg);
    bp_proc_param_s p;
    case (cfg)
      e_bp_default_cfg: p = '{paddr_width: 40, did_width: 3, lce_id_width: 4, lce_assoc: 8};
      default:          p = '{paddr_width: 40, did_width: 3, lce_id_width: 4, lce_assoc: 8};
    endcase
    return p;
  endfunction

  // Header layout, MSB to LSB: payload {did, lce_id, way_id}, size, addr, subop, msg_type.
  function automatic int unsigned cce_mem_header_width(bp_params_e cfg);
    bp_proc_param_s p;
    p = bp_get_proc_params(cfg);
    return 4 + 4 + p.paddr_width + 3 + p.did_width + p.lce_id_width + $clog2(p.lce_assoc);
  endfunction

  localparam int unsigned dword_width_gp    = 64;
  localparam int unsigned dev_addr_width_gp = 20;

  localparam logic [dev_addr_width_gp-1:0] cfg_reg_freeze_gp          = 20'h0_0008;
  localparam logic [dev_addr_width_gp-1:0] cfg_reg_hio_mask_gp        = 20'h0_0028;
  localparam logic [dev_addr_width_gp-1:0] cfg_reg_icache_mode_gp     = 20'h0_0200;
  localparam logic [dev_addr_width_gp-1:0] cfg_reg_dcache_mode_gp     = 20'h0_0400;
  localparam logic [dev_addr_width_gp-1:0] cfg_reg_cce_mode_gp        = 20'h0_0600;
  localparam logic [dev_addr_width_gp-1:0] cfg_mem_cce_ucode_base_gp  = 20'h0_8000;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'b0000,
    e_bedrock_mem_wr    = 4'b0001,
    e_bedrock_mem_uc_rd = 4'b0010,
    e_bedrock_mem_uc_wr = 4'b0011
  } bp_bedrock_mem_type_e;

endpackage

module bp_cce_cfg_endpoint
  import bp_cce_cfg_endpoint_pkg::*;
#(
  parameter bp_params_e  bp_params_p           = e_bp_default_cfg,
  parameter int unsigned inst_ram_addr_width_p = 8,
  localparam int unsigned cce_mem_header_width_lp = cce_mem_header_width(bp_params_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,

  input  logic [cce_mem_header_width_lp-1:0] io_cmd_header_i,
  input  logic [dword_width_gp-1:0]          io_cmd_data_i,
  input  logic                               io_cmd_v_i,
  input  logic                               io_cmd_last_i,
  output logic                               io_cmd_ready_and_o,

  output logic [cce_mem_header_width_lp-1:0] io_resp_header_o,
  output logic [dword_width_gp-1:0]          io_resp_data_o,
  output logic                               io_resp_v_o,
  output logic                               io_resp_last_o,
  input  logic                               io_resp_ready_and_i,

  output logic                               freeze_o,
  output logic                               icache_mode_o,
  output logic                               dcache_mode_o,
  output logic                               cce_mode_o,
  output logic [dword_width_gp-1:0]          hio_mask_o,

  output logic                               ucode_v_o,
  output logic                               ucode_w_o,
  output logic [inst_ram_addr_width_p-1:0]   ucode_addr_o,
  output logic [dword_width_gp-1:0]          ucode_data_o,
  input  logic [dword_width_gp-1:0]          ucode_data_i
);

  typedef enum logic [1:0] {StReady, StUcodeRd, StResp} state_e;

  localparam logic [dev_addr_width_gp:0] ucode_lo_lp = {1'b0, cfg_mem_cce_ucode_base_gp};
  localparam logic [dev_addr_width_gp:0] ucode_hi_lp =
    ucode_lo_lp + ((dev_addr_width_gp+1)'(8) << inst_ram_addr_width_p);

  state_e state_q, state_d;
  logic freeze_q, freeze_d;
  logic icache_mode_q, icache_mode_d;
  logic dcache_mode_q, dcache_mode_d;
  logic cce_mode_q, cce_mode_d;
  logic [dword_width_gp-1:0] hio_mask_q, hio_mask_d;
  logic [cce_mem_header_width_lp-1:0] resp_header_q, resp_header_d;
  logic [dword_width_gp-1:0] resp_data_q, resp_data_d;

  logic [dev_addr_width_gp-1:0] cmd_dev_addr;
  logic cmd_accept, is_wr;
  logic sel_freeze, sel_icache, sel_dcache, sel_cce, sel_hio, sel_ucode;
  logic ucode_v, ucode_w;

  // Only single-beat commands are legal, so the last flag carries no information.
  logic unused_cmd_last;
  assign unused_cmd_last = io_cmd_last_i;

  assign cmd_dev_addr = io_cmd_header_i[8 +: dev_addr_width_gp];
  assign is_wr        = (io_cmd_header_i[3:0] == e_bedrock_mem_uc_wr);

  assign sel_freeze = (cmd_dev_addr == cfg_reg_freeze_gp);
  assign sel_icache = (cmd_dev_addr == cfg_reg_icache_mode_gp);
  assign sel_dcache = (cmd_dev_addr == cfg_reg_dcache_mode_gp);
  assign sel_cce    = (cmd_dev_addr == cfg_reg_cce_mode_gp);
  assign sel_hio    = (cmd_dev_addr == cfg_reg_hio_mask_gp);
  assign sel_ucode  = ({1'b0, cmd_dev_addr} >= ucode_lo_lp) && ({1'b0, cmd_dev_addr} < ucode_hi_lp);

  // Handshakes are gated by reset so nothing is accepted or emitted in a reset cycle.
  assign io_cmd_ready_and_o = (state_q == StReady) & ~reset_i;
  assign cmd_accept         = io_cmd_v_i & io_cmd_ready_and_o;

`ifdef BP_CFG_ENDPOINT_RD_EN
  logic is_rd;
  logic [dword_width_gp-1:0] rd_val;

  assign is_rd = (io_cmd_header_i[3:0] == e_bedrock_mem_uc_rd);

  always_comb begin
    rd_val = '0;
    if (sel_freeze) rd_val[0] = freeze_q;
    if (sel_icache) rd_val[0] = icache_mode_q;
    if (sel_dcache) rd_val[0] = dcache_mode_q;
    if (sel_cce)    rd_val[0] = cce_mode_q;
    if (sel_hio)    rd_val    = hio_mask_q;
  end
`else
  logic [dword_width_gp-1:0] unused_ucode_data;
  assign unused_ucode_data = ucode_data_i;
`endif

  always_comb begin
    state_d       = state_q;
    freeze_d      = freeze_q;
    icache_mode_d = icache_mode_q;
    dcache_mode_d = dcache_mode_q;
    cce_mode_d    = cce_mode_q;
    hio_mask_d    = hio_mask_q;
    resp_header_d = resp_header_q;
    resp_data_d   = resp_data_q;
    ucode_v       = 1'b0;
    ucode_w       = 1'b0;

    unique case (state_q)
      StReady: begin
        if (cmd_accept) begin
          resp_header_d = io_cmd_header_i;
          resp_data_d   = '0;
          state_d       = StResp;
          if (is_wr) begin
            if (sel_freeze) freeze_d      = io_cmd_data_i[0];
            if (sel_icache) icache_mode_d = io_cmd_data_i[0];
            if (sel_dcache) dcache_mode_d = io_cmd_data_i[0];
            if (sel_cce)    cce_mode_d    = io_cmd_data_i[0];
            if (sel_hio)    hio_mask_d    = io_cmd_data_i;
            if (sel_ucode) begin
              ucode_v = 1'b1;
              ucode_w = 1'b1;
            end
          end
`ifdef BP_CFG_ENDPOINT_RD_EN
          else if (is_rd) begin
            resp_data_d = rd_val;
            if (sel_ucode) begin
              ucode_v = 1'b1;
              state_d = StUcodeRd;
            end
          end
`endif
        end
      end
      StUcodeRd: begin
`ifdef BP_CFG_ENDPOINT_RD_EN
        // RAM returns data one cycle after the read strobe.
        resp_data_d = ucode_data_i;
`endif
        state_d = StResp;
      end
      StResp: begin
        if (io_resp_ready_and_i) state_d = StReady;
      end
      default: state_d = StReady;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StReady;
      freeze_q      <= 1'b1;
      icache_mode_q <= 1'b0;
      dcache_mode_q <= 1'b0;
      cce_mode_q    <= 1'b0;
      hio_mask_q    <= '0;
      resp_header_q <= '0;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      freeze_q      <= freeze_d;
      icache_mode_q <= icache_mode_d;
      dcache_mode_q <= dcache_mode_d;
      cce_mode_q    <= cce_mode_d;
      hio_mask_q    <= hio_mask_d;
      resp_header_q <= resp_header_d;
      resp_data_q   <= resp_data_d;
    end
  end

  assign io_resp_v_o      = (state_q == StResp) & ~reset_i;
  assign io_resp_last_o   = io_resp_v_o;
  assign io_resp_header_o = resp_header_q;
  assign io_resp_data_o   = resp_data_q;

  assign freeze_o      = freeze_q;
  assign icache_mode_o = icache_mode_q;
  assign dcache_mode_o = dcache_mode_q;
  assign cce_mode_o    = cce_mode_q;
  assign hio_mask_o    = hio_mask_q;

  assign ucode_v_o    = ucode_v;
  assign ucode_w_o    = ucode_w;
  assign ucode_addr_o = inst_ram_addr_width_p'((cmd_dev_addr - cfg_mem_cce_ucode_base_gp) >> 3);
  assign ucode_data_o = io_cmd_data_i;

endmodule

// File: tb/tb_bp_cce_cfg_endpoint.sv
// Bench for bp_cce_cfg_endpoint: directed vector table, corner sequences, random vs. model.
module tb_bp_cce_cfg_endpoint;
  import bp_cce_cfg_endpoint_pkg::*;

  localparam int unsigned HW = 61;
`ifdef BP_CFG_ENDPOINT_RD_EN
  localparam bit RdEn = 1'b1;
`else
  localparam bit RdEn = 1'b0;
`endif
  localparam logic [3:0] UcRd = 4'b0010;
  localparam logic [3:0] UcWr = 4'b0011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [HW-1:0] cmd_hdr = '0;
  logic [63:0] cmd_data = '0;
  logic cmd_v = 1'b0, cmd_last = 1'b1, cmd_ready;
  logic [HW-1:0] resp_hdr;
  logic [63:0] resp_data;
  logic resp_v, resp_last, resp_ready = 1'b0;
  logic freeze, icm, dcm, ccm;
  logic [63:0] hio;
  logic uv, uw;
  logic [7:0] uaddr;
  logic [63:0] udata_o, udata_i = '0;

  always #5 clk = ~clk;

  bp_cce_cfg_endpoint dut (
    .clk_i(clk), .reset_i(reset),
    .io_cmd_header_i(cmd_hdr), .io_cmd_data_i(cmd_data), .io_cmd_v_i(cmd_v),
    .io_cmd_last_i(cmd_last), .io_cmd_ready_and_o(cmd_ready),
    .io_resp_header_o(resp_hdr), .io_resp_data_o(resp_data), .io_resp_v_o(resp_v),
    .io_resp_last_o(resp_last), .io_resp_ready_and_i(resp_ready),
    .freeze_o(freeze), .icache_mode_o(icm), .dcache_mode_o(dcm), .cce_mode_o(ccm),
    .hio_mask_o(hio),
    .ucode_v_o(uv), .ucode_w_o(uw), .ucode_addr_o(uaddr), .ucode_data_o(udata_o),
    .ucode_data_i(udata_i)
  );

  // Ucode RAM the endpoint talks to.
  logic [63:0] ram [256] = '{default: '0};
  int n_resp_seen = 0, n_uv_seen = 0;
  always @(posedge clk) begin
    if (uv) begin
      if (uw) ram[uaddr] <= udata_o;
      else udata_i <= ram[uaddr];
    end
    if (!reset && resp_v && resp_ready) n_resp_seen <= n_resp_seen + 1;
    if (uv) n_uv_seen <= n_uv_seen + 1;
  end

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural state indexed by address.
  logic m_freeze = 1'b1, m_ic = 1'b0, m_dc = 1'b0, m_cce = 1'b0;
  logic [63:0] m_hio = '0;
  logic [63:0] m_ucode [256] = '{default: '0};
  int exp_resps = 0, exp_uv = 0;

  task automatic model_reset();
    m_freeze = 1'b1; m_ic = 1'b0; m_dc = 1'b0; m_cce = 1'b0; m_hio = '0;
  endtask

  task automatic model_cmd(input logic [3:0] mt, input logic [19:0] a, input logic [63:0] d,
                           output logic [63:0] ed, output logic euv, output logic euw,
                           output logic [7:0] eua, output int elat);
    bit in_uc;
    int idx;
    in_uc = (a >= 20'h8000) && (a < 20'h8000 + 20'd2048);
    idx = in_uc ? int'((a - 20'h8000) / 8) : 0;
    ed = '0; euv = 1'b0; euw = 1'b0; eua = 8'(idx); elat = 1;
    if (mt == UcWr) begin
      if (a == 20'h00008) m_freeze = d[0];
      if (a == 20'h00200) m_ic = d[0];
      if (a == 20'h00400) m_dc = d[0];
      if (a == 20'h00600) m_cce = d[0];
      if (a == 20'h00028) m_hio = d;
      if (in_uc) begin m_ucode[idx] = d; euv = 1'b1; euw = 1'b1; end
    end else if (RdEn) begin
      if (a == 20'h00008) ed = 64'(m_freeze);
      if (a == 20'h00200) ed = 64'(m_ic);
      if (a == 20'h00400) ed = 64'(m_dc);
      if (a == 20'h00600) ed = 64'(m_cce);
      if (a == 20'h00028) ed = m_hio;
      if (in_uc) begin ed = m_ucode[idx]; euv = 1'b1; elat = 2; end
    end
    if (euv) exp_uv++;
  endtask

  task automatic do_cmd(input string tag, input logic [3:0] mt, input logic [39:0] addr,
                        input logic [63:0] d, input int stall, output logic [63:0] got);
    logic [HW-1:0] hdr;
    logic [63:0] ed;
    logic euv, euw;
    logic [7:0] eua;
    int elat, lat, n;
    got = '0;
    hdr = {10'($urandom), 3'b011, addr, 4'b0000, mt};
    model_cmd(mt, addr[19:0], d, ed, euv, euw, eua, elat);
    @(negedge clk);
    cmd_hdr = hdr; cmd_data = d; cmd_v = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    if (!cmd_ready) begin cmd_v = 1'b0; return; end
    #1;
    chk({tag, " ucode_v"}, 64'(uv), 64'(euv));
    if (euv) begin
      chk({tag, " ucode_w"}, 64'(uw), 64'(euw));
      chk({tag, " ucode_addr"}, 64'(uaddr), 64'(eua));
      if (euw) chk({tag, " ucode_data"}, udata_o, d);
    end
    @(posedge clk); #1 cmd_v = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_v && lat < 20);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    if (!resp_v) return;
    got = resp_data;
    chk({tag, " resp_hdr"}, 64'(resp_hdr ^ hdr), 64'd0);
    chk({tag, " resp_data"}, resp_data, ed);
    chk({tag, " resp_last"}, 64'(resp_last), 64'd1);
    for (int i = 0; i < stall; i++) begin
      chk({tag, " stall cmd_ready"}, 64'(cmd_ready), 64'd0);
      chk({tag, " stall resp_v"}, 64'(resp_v), 64'd1);
      chk({tag, " stall data"}, resp_data, got);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    exp_resps++;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic chk_regs(input string tag, input logic [3:0] em, input logic [63:0] eh);
    chk({tag, " modes"}, 64'({freeze, icm, dcm, ccm}), 64'(em));
    chk({tag, " hio"}, hio, eh);
  endtask

  typedef struct {
    logic [3:0]  mt;
    logic [19:0] a;
    logic [63:0] d;
    int          stall;
    logic [63:0] exp_data;
    logic [3:0]  exp_modes;  // {freeze, icache, dcache, cce}
    logic [63:0] exp_hio;
  } vec_t;

  localparam logic [63:0] Hio = 64'h1111_1111_0000_0001;

  initial begin
    vec_t vt [16];
    logic [63:0] got;
    vt[0]  = '{UcWr, 20'h00008, 64'h0,  0, 64'h0, 4'b0000, 64'h0};
    vt[1]  = '{UcRd, 20'h00008, 64'h0,  0, 64'h0, 4'b0000, 64'h0};
    vt[2]  = '{UcWr, 20'h00600, 64'h1,  0, 64'h0, 4'b0001, 64'h0};
    vt[3]  = '{UcRd, 20'h00600, 64'h0,  1, RdEn ? 64'h1 : 64'h0, 4'b0001, 64'h0};
    vt[4]  = '{UcWr, 20'h00200, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h0, 4'b0001, 64'h0};
    vt[5]  = '{UcWr, 20'h00400, 64'h3,  0, 64'h0, 4'b0011, 64'h0};
    vt[6]  = '{UcWr, 20'h00028, Hio,    5, 64'h0, 4'b0011, Hio};
    vt[7]  = '{UcRd, 20'h00028, 64'h0,  0, RdEn ? Hio : 64'h0, 4'b0011, Hio};
    vt[8]  = '{UcWr, 20'h08018, 64'hABCD, 0, 64'h0, 4'b0011, Hio};
    vt[9]  = '{UcRd, 20'h08018, 64'h0,  0, RdEn ? 64'hABCD : 64'h0, 4'b0011, Hio};
    vt[10] = '{UcWr, 20'h00100, 64'hFF, 0, 64'h0, 4'b0011, Hio};
    vt[11] = '{UcRd, 20'h00100, 64'h0,  0, 64'h0, 4'b0011, Hio};
    vt[12] = '{UcWr, 20'h00008, 64'h1,  0, 64'h0, 4'b1011, Hio};
    vt[13] = '{UcWr, 20'h087F8, 64'h55, 0, 64'h0, 4'b1011, Hio};
    vt[14] = '{UcWr, 20'h08800, 64'h77, 0, 64'h0, 4'b1011, Hio};
    vt[15] = '{UcRd, 20'h087F8, 64'h0,  2, RdEn ? 64'h55 : 64'h0, 4'b1011, Hio};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_regs("reset", 4'b1000, 64'h0);
    chk("reset resp_v", 64'(resp_v), 64'd0);
    chk("reset cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_cmd(tag, vt[i].mt, {20'h0, vt[i].a}, vt[i].d, vt[i].stall, got);
      chk({tag, " table data"}, got, vt[i].exp_data);
      chk_regs(tag, vt[i].exp_modes, vt[i].exp_hio);
    end

    // Reset while a response is pending: it must vanish.
    @(negedge clk);
    cmd_hdr = {10'h0, 3'b011, 40'h00200, 4'b0000, UcWr}; cmd_data = 64'h1; cmd_v = 1'b1;
    @(posedge clk); #1 cmd_v = 1'b0;
    @(negedge clk);
    chk("rst-in-resp resp_v before", 64'(resp_v), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst-in-resp resp_v in reset", 64'(resp_v), 64'd0);
    reset = 1'b0;
    model_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst-in-resp resp_v after", 64'(resp_v), 64'd0);
      chk("rst-in-resp cmd_ready", 64'(cmd_ready), 64'd1);
    end
    resp_ready = 1'b0;
    chk_regs("rst-in-resp", 4'b1000, 64'h0);

    for (int i = 0; i < 80; i++) begin
      logic [19:0] a;
      logic [3:0] mt;
      int k;
      k = $urandom_range(0, 7);
      case (k)
        0: a = 20'h00008;
        1: a = 20'h00200;
        2: a = 20'h00400;
        3: a = 20'h00600;
        4: a = 20'h00028;
        5, 6: a = 20'h08000 + 20'(8 * $urandom_range(0, 255));
        default: a = 20'h04000 + 20'(8 * $urandom_range(0, 255));
      endcase
      mt = ($urandom_range(0, 1) == 1) ? UcWr : UcRd;
      do_cmd($sformatf("rnd%0d", i), mt, {20'($urandom), a}, {$urandom, $urandom},
             $urandom_range(0, 2), got);
      chk_regs($sformatf("rnd%0d", i), {m_freeze, m_ic, m_dc, m_cce}, m_hio);
    end

    repeat (3) @(negedge clk);
    chk("response count", 64'(n_resp_seen), 64'(exp_resps));
    chk("ucode strobe count", 64'(n_uv_seen), 64'(exp_uv));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_cce_cfg_endpoint.md
BP_CCE_CFG_ENDPOINT -- requirements
Module: bp_cce_cfg_endpoint

Interface
REQ-001 SHALL take parameter bp_params_p, default e_bp_default_cfg, supplying paddr_width_p, did_width_p, lce_id_width_p, lce_assoc_p and the cce mem header width.
REQ-002 SHALL take parameter inst_ram_addr_width_p, default 8, giving the ucode RAM word-address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports io_cmd_header_i, input, cce_mem_header_width_lp, and io_cmd_data_i, input, dword_width_gp: the cmd BedRock stream from the cfg loader.
REQ-006 SHALL have ports io_cmd_v_i, input, 1; io_cmd_last_i, input, 1; and io_cmd_ready_and_o, output, 1.
REQ-007 SHALL have ports io_resp_header_o, output, cce_mem_header_width_lp; io_resp_data_o, output, dword_width_gp; io_resp_v_o, output, 1; io_resp_last_o, output, 1; io_resp_ready_and_i, input, 1.
REQ-008 SHALL have ports freeze_o, 1; icache_mode_o, 1; dcache_mode_o, 1; cce_mode_o, 1; hio_mask_o, dword_width_gp; all outputs, each a register value.
REQ-009 SHALL have ports ucode_v_o, output, 1; ucode_w_o, output, 1; ucode_addr_o, output, inst_ram_addr_width_p; ucode_data_o, output, dword_width_gp; ucode_data_i, input, dword_width_gp (valid 1 cycle after a read strobe).

Function
REQ-010 SHALL be an FSM with states READY, UCODE_RD, RESP.
REQ-011 In READY, io_cmd_ready_and_o SHALL be 1; a cmd is accepted when io_cmd_v_i & io_cmd_ready_and_o; in UCODE_RD and RESP it SHALL be 0.
REQ-012 Only single-beat cmds (io_cmd_last_i=1, size 8B) are legal; multi-beat input is undefined.
REQ-013 The address SHALL be decoded using addr[dev_addr_width_gp-1:0] against cfg_reg_freeze_gp, cfg_reg_icache_mode_gp, cfg_reg_dcache_mode_gp, cfg_reg_cce_mode_gp, cfg_reg_hio_mask_gp, and the ucode window [cfg_mem_cce_ucode_base_gp, base + 8*2^inst_ram_addr_width_p).
REQ-014 An accepted e_bedrock_mem_uc_wr to a register SHALL update it on the acceptance edge using data[0] (mode/freeze bits) or the full dword (hio mask), then go to RESP.
REQ-015 An accepted uc_wr to the ucode window SHALL assert ucode_v_o=ucode_w_o=1 in the acceptance cycle, with ucode_addr_o=(addr-base)>>3 and ucode_data_o=io_cmd_data_i, then go to RESP.
REQ-016 An accepted uc_rd to a register SHALL capture the zero-extended value into the response data register, then go to RESP.
REQ-017 An accepted uc_rd to ucode SHALL assert ucode_v_o=1, ucode_w_o=0 in the acceptance cycle, go to UCODE_RD, capture ucode_data_i there, then go to RESP.
REQ-018 Unmapped addresses SHALL leave state unchanged, return data 0, and still produce a response.
REQ-019 In RESP, io_resp_v_o SHALL be 1 with the header equal to the captured cmd header (msg_type, addr, size, payload unchanged) and io_resp_last_o=1; on io_resp_ready_and_i it SHALL return to READY.
REQ-020 Write responses SHALL carry data 0.
REQ-021 Exactly one response SHALL be produced per cmd; minimum cmd-to-resp latency SHALL be 1 cycle for registers and 2 cycles for ucode reads.
REQ-022 ucode_v_o SHALL be 0 in all cycles other than those defined in REQ-015 and REQ-017.

Reset
REQ-023 On reset_i the FSM SHALL enter READY and all outputs SHALL take these values: freeze_o=1, icache_mode_o=0, dcache_mode_o=0, cce_mode_o=0 (uncached), hio_mask_o=0, io_resp_v_o=0, ucode_v_o=0.
REQ-024 Reset asserted mid-transaction SHALL drop any pending response without emitting it.

Configuration
REQ-025 With macro BP_CFG_ENDPOINT_RD_EN defined, reads SHALL behave as in REQ-016/REQ-017; without it, every uc_rd SHALL return data 0 from READY directly to RESP, ucode_w_o=0 reads SHALL never be issued, and UCODE_RD SHALL be unreachable.

Verification
REQ-026 After reset, before any cmd: freeze_o=1, all modes 0, hio_mask_o=0, io_resp_v_o=0.
REQ-027 uc_wr freeze data=0 -> freeze_o=0 on the next cycle; one response with data 0 and header equal to the cmd header.
REQ-028 uc_wr to ucode base+0x18 data=0xABCD -> one-cycle ucode write with addr=3, data=0xABCD; then uc_rd of the same address (RD_EN) with ucode_data_i=0xABCD -> response data 0xABCD, 2 cycles after acceptance.
REQ-029 uc_wr hio_mask 0x1111_1111_0000_0001 with io_resp_ready_and_i held 0 for 5 cycles -> io_resp_v_o held stable and io_cmd_ready_and_o=0 throughout; exactly one response is emitted.
REQ-030 Unmapped addr write of 0xFF -> no register change, response data 0; reset asserted while in RESP -> no response emitted, FSM in READY.
REQ-031 Without BP_CFG_ENDPOINT_RD_EN: uc_rd of cce_mode after writing 1 -> response data 0, ucode_v_o never asserted.
